// File: rtl/uart_wishbone_bridge_pkg.sv
// Shared command codes and state encodings for the UART-to-Wishbone debug bridge.
package uart_wishbone_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_WDATA = 3'd3,
    ST_WBUS  = 3'd4,
    ST_RBUS  = 3'd5,
    ST_RSEND = 3'd6
  } parser_state_t;

  typedef enum logic [1:0] {
    RX_HUNT  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_phy.sv
// 8N1 UART receiver and transmitter, CLK_DIV clock cycles per bit.
// tx handshake: a byte moves when tx_valid && tx_ready on a rising edge;
// tx_ready is also high in the last stop-bit cycle so bytes go out back-to-back.
module uart_phy
  import uart_wishbone_bridge_pkg::*;
#(
  parameter int CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] rx_data,
  output logic       rx_stb,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [1:0] dbg_rx_state
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 2;
  localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);

  rx_state_t     rx_state;
  logic          rx_s1, rx_s2, rx_s3;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;

  logic          tx_busy;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_sh;

  assign dbg_rx_state = rx_state;

  // rx_s3 is the previous synchronised sample, used only for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= RX_HUNT;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_stb   <= 1'b0;
    end else begin
      rx_s1  <= rx;
      rx_s2  <= rx_s1;
      rx_s3  <= rx_s2;
      rx_stb <= 1'b0;
      case (rx_state)
        RX_HUNT: begin
          if (rx_s3 && !rx_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_HUNT : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == FULL) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == FULL) begin
            rx_cnt   <= '0;
            rx_state <= RX_HUNT;
            if (rx_s2) begin
              rx_data <= rx_sh;
              rx_stb  <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: rx_state <= RX_HUNT;
      endcase
    end
  end

  assign tx_ready = !tx_busy || ((tx_bit == 4'd9) && (tx_cnt == FULL));

  // tx_bit 0 is the start bit, 1..8 data, 9 stop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '0;
    end else if (tx_valid && tx_ready) begin
      tx      <= 1'b0;
      tx_busy <= 1'b1;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= {1'b1, tx_data};
    end else if (tx_busy) begin
      if (tx_cnt == FULL) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
          tx      <= 1'b1;
        end else begin
          tx     <= tx_sh[0];
          tx_sh  <= {1'b1, tx_sh[8:1]};
          tx_bit <= tx_bit + 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_wishbone_bridge.sv
// Host debug bridge: parses CMD/LEN/ADDR/payload frames from the UART and
// runs 32-bit Wishbone master cycles, returning read data over the UART.
module uart_wishbone_bridge
  import uart_wishbone_bridge_pkg::*;
#(
  parameter int CLK_DIV = 868,
  parameter int TIMEOUT = 2000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [29:0] wb_adr,
  output logic [31:0] wb_dat_w,
  output logic [3:0]  wb_sel,
  input  logic [31:0] wb_dat_r,
  input  logic        wb_ack,
  input  logic        wb_err,
  output logic        busy,
  output logic [4:0]  dbg_state
);

  localparam int TW = $clog2(TIMEOUT + 1);

  parser_state_t state;
  logic          is_read;
  logic [7:0]    words_left;
  logic [2:0]    byte_cnt;
  logic [31:0]   shift_q;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  logic [7:0]    rx_data;
  logic          rx_stb;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [1:0]    dbg_rx_state;

  uart_phy #(.CLK_DIV(CLK_DIV)) u_phy (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (uart_rx),
    .tx           (uart_tx),
    .rx_data      (rx_data),
    .rx_stb       (rx_stb),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .dbg_rx_state (dbg_rx_state)
  );

  assign wb_stb    = wb_cyc;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = {dbg_rx_state, state};
  assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT - 1));
  // byte_cnt == 4 in RSEND means all four bytes handed over, waiting for the last to finish
  assign tx_valid  = (state == ST_RSEND) && (byte_cnt != 3'd4);
  assign tx_data   = shift_q[31:24];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      is_read    <= 1'b0;
      words_left <= '0;
      byte_cnt   <= '0;
      shift_q    <= '0;
      tmo_cnt    <= '0;
      wb_cyc     <= 1'b0;
      wb_we      <= 1'b0;
      wb_adr     <= '0;
      wb_dat_w   <= '0;
      wb_sel     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_stb && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
            is_read <= (rx_data == CMD_READ);
            tmo_cnt <= '0;
            state   <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (rx_stb) begin
            words_left <= rx_data;
            byte_cnt   <= '0;
            tmo_cnt    <= '0;
            state      <= ST_ADDR;
          end else if (tmo_hit) begin
            state <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_ADDR: begin
          if (rx_stb) begin
            shift_q <= {shift_q[23:0], rx_data};
            tmo_cnt <= '0;
            if (byte_cnt == 3'd3) begin
              byte_cnt <= '0;
              wb_adr   <= {shift_q[21:0], rx_data};
              if (words_left == 8'd0) begin
                state <= ST_IDLE;
              end else if (is_read) begin
                wb_cyc <= 1'b1;
                wb_we  <= 1'b0;
                wb_sel <= 4'hF;
                state  <= ST_RBUS;
              end else begin
                state <= ST_WDATA;
              end
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end else if (tmo_hit) begin
            state <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_WDATA: begin
          if (rx_stb) begin
            shift_q <= {shift_q[23:0], rx_data};
            tmo_cnt <= '0;
            if (byte_cnt == 3'd3) begin
              byte_cnt <= '0;
              wb_dat_w <= {shift_q[23:0], rx_data};
              wb_cyc   <= 1'b1;
              wb_we    <= 1'b1;
              wb_sel   <= 4'hF;
              state    <= ST_WBUS;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end else if (tmo_hit) begin
            state <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        // An error ends the cycle like an ack; the write simply moves on
        ST_WBUS: begin
          if (wb_ack || wb_err) begin
            wb_cyc     <= 1'b0;
            wb_we      <= 1'b0;
            wb_sel     <= 4'h0;
            wb_adr     <= wb_adr + 30'd1;
            words_left <= words_left - 8'd1;
            tmo_cnt    <= '0;
            state      <= (words_left == 8'd1) ? ST_IDLE : ST_WDATA;
          end
        end
        ST_RBUS: begin
          if (wb_ack || wb_err) begin
            wb_cyc     <= 1'b0;
            wb_sel     <= 4'h0;
            wb_adr     <= wb_adr + 30'd1;
            words_left <= words_left - 8'd1;
            shift_q    <= wb_err ? 32'h0 : wb_dat_r;
            byte_cnt   <= '0;
            state      <= ST_RSEND;
          end
        end
        ST_RSEND: begin
          if (byte_cnt == 3'd4) begin
            if (tx_ready) begin
              if (words_left == 8'd0) begin
                state <= ST_IDLE;
              end else begin
                wb_cyc <= 1'b1;
                wb_sel <= 4'hF;
                state  <= ST_RBUS;
              end
            end
          end else if (tx_ready) begin
            shift_q  <= {shift_q[23:0], 8'h00};
            byte_cnt <= byte_cnt + 3'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wishbone_bridge.sv
// Directed bench for uart_wishbone_bridge: UART host driver, Wishbone slave
// model, UART TX monitor and scoreboard queues.
module tb_uart_wishbone_bridge;

  localparam int CLK_DIV = 16;
  localparam int TIMEOUT = 1000;
  localparam int BIT_T   = CLK_DIV * 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic        wb_cyc, wb_stb, wb_we;
  logic [29:0] wb_adr;
  logic [31:0] wb_dat_w;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_r;
  logic        wb_ack, wb_err;
  logic        busy;
  logic [4:0]  dbg_state;

  int total = 0;
  int bad = 0;

  logic [66:0] exp_q[$];
  logic [66:0] got_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [7:0]  txb_q[$];
  time         txt_q[$];
  logic [7:0]  frame[$];
  int          tx_stop_err = 0;

  int          slave_wait = 0;
  logic        slave_err = 1'b0;
  logic [31:0] slave_rdata = 32'h0;

  uart_wishbone_bridge #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .uart_tx   (uart_tx),
    .wb_cyc    (wb_cyc),
    .wb_stb    (wb_stb),
    .wb_we     (wb_we),
    .wb_adr    (wb_adr),
    .wb_dat_w  (wb_dat_w),
    .wb_sel    (wb_sel),
    .wb_dat_r  (wb_dat_r),
    .wb_ack    (wb_ack),
    .wb_err    (wb_err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [66:0] mk(input logic we, input logic [29:0] adr, input logic [31:0] dat);
    return {4'hF, we, adr, dat};
  endfunction

  // UART host driver; bit edges land on falling clock edges
  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_rx = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      #(BIT_T);
    end
    uart_rx = stop;
    #(BIT_T);
    uart_rx = 1'b1;
    if (!stop) #(BIT_T);
  endtask

  task automatic send_frame();
    while (frame.size() > 0) send_byte(frame.pop_front(), 1'b1);
  endtask

  // Wishbone slave: acks or errors after slave_wait wait states, logs each cycle
  initial begin
    int ws;
    ws = 0;
    wb_ack = 1'b0;
    wb_err = 1'b0;
    wb_dat_r = 32'h0;
    forever begin
      @(negedge clk);
      if (wb_ack || wb_err || !wb_cyc) begin
        wb_ack = 1'b0;
        wb_err = 1'b0;
        wb_dat_r = 32'h0;
        ws = 0;
      end else if (ws >= slave_wait) begin
        wb_ack = !slave_err;
        wb_err = slave_err;
        wb_dat_r = slave_rdata;
        got_q.push_back({wb_sel, wb_we, wb_adr, wb_we ? wb_dat_w : 32'h0});
      end else begin
        ws++;
      end
    end
  end

  // UART TX monitor: samples at bit centres, records byte and start time
  initial begin
    logic [7:0] b;
    time t0;
    forever begin
      @(negedge uart_tx);
      t0 = $time;
      #(BIT_T / 2);
      for (int i = 0; i < 8; i++) begin
        #(BIT_T);
        b[i] = uart_tx;
      end
      #(BIT_T);
      if (uart_tx !== 1'b1) tx_stop_err++;
      txb_q.push_back(b);
      txt_q.push_back(t0);
    end
  end

  task automatic check_bus(input string tag, input int budget);
    int k;
    k = 0;
    while (got_q.size() < exp_q.size() && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check(tag, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic check_tx(input string tag, input int budget);
    int k;
    int n;
    k = 0;
    n = exp_tx_q.size();
    while (txb_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check({tag, "_count"}, txb_q.size(), n);
    for (int i = 0; i < n && i < txb_q.size(); i++) begin
      check(tag, txb_q[i], exp_tx_q[i]);
      if (i % 4 != 0)
        check({tag, "_gap"}, txt_q[i] - txt_q[i-1], 10 * BIT_T);
    end
    exp_tx_q.delete();
    txb_q.delete();
    txt_q.delete();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_wb_cyc", wb_cyc, 1'b0);
    check("rst_wb_stb", wb_stb, 1'b0);
    check("rst_wb_we", wb_we, 1'b0);
    check("rst_wb_adr", wb_adr, 30'h0);
    check("rst_wb_dat_w", wb_dat_w, 32'h0);
    check("rst_wb_sel", wb_sel, 4'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, 5'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // single-word write
    frame = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h24, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0E};
    exp_q.push_back(mk(1'b1, 30'h2400, 32'h0000000E));
    send_frame();
    check_bus("wr1", 200);
    check("wr1_busy", busy, 1'b0);

    // single-word read, 3 wait states
    slave_wait = 3;
    slave_rdata = 32'h12345678;
    frame = '{8'h02, 8'h01, 8'h04, 8'h00, 8'h00, 8'h00};
    exp_q.push_back(mk(1'b0, 30'h04000000, 32'h0));
    exp_tx_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    send_frame();
    check_bus("rd1", 200);
    check_tx("rd1_tx", 60 * CLK_DIV);
    repeat (CLK_DIV) @(negedge clk);
    check("rd1_busy", busy, 1'b0);
    slave_wait = 0;

    // two-word write wrapping the address
    frame = '{8'h01, 8'h02, 8'h3F, 8'hFF, 8'hFF, 8'hFF,
              8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
    exp_q.push_back(mk(1'b1, 30'h3FFFFFFF, 32'hAABBCCDD));
    exp_q.push_back(mk(1'b1, 30'h00000000, 32'h11223344));
    send_frame();
    check_bus("wrap", 200);

    // inter-byte timeout mid-ADDR, then a good frame
    frame = '{8'h01, 8'h01, 8'h00};
    send_frame();
    repeat (TIMEOUT - 100) @(negedge clk);
    check("tmo_busy_before", busy, 1'b1);
    repeat (200) @(negedge clk);
    check("tmo_busy_after", busy, 1'b0);
    check_bus("tmo_nocycle", 10);
    frame = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    exp_q.push_back(mk(1'b1, 30'h10, 32'hCAFEBABE));
    send_frame();
    check_bus("tmo_recover", 200);

    // framing error inside ADDR: bad byte is dropped
    frame = '{8'h01, 8'h01, 8'h00, 8'h00};
    send_frame();
    send_byte(8'h55, 1'b0);
    frame = '{8'h00, 8'h20};
    send_frame();
    check("ferr_busy", busy, 1'b1);
    frame = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    exp_q.push_back(mk(1'b1, 30'h20, 32'hDEADBEEF));
    send_frame();
    check_bus("ferr", 200);

    // unknown command
    send_byte(8'h7F, 1'b1);
    repeat (4) @(negedge clk);
    check("badcmd_busy", busy, 1'b0);

    // LEN = 0: header only
    frame = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05};
    send_frame();
    check_bus("len0", 20);
    check("len0_busy", busy, 1'b0);

    // read answered with wb_err returns zeros
    slave_err = 1'b1;
    slave_rdata = 32'hFFFFFFFF;
    frame = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h08};
    exp_q.push_back(mk(1'b0, 30'h08, 32'h0));
    exp_tx_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_frame();
    check_bus("rderr", 200);
    check_tx("rderr_tx", 60 * CLK_DIV);
    slave_err = 1'b0;

    // two-word read
    slave_rdata = 32'hCAFEF00D;
    frame = '{8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 8'h40};
    exp_q.push_back(mk(1'b0, 30'h40, 32'h0));
    exp_q.push_back(mk(1'b0, 30'h41, 32'h0));
    exp_tx_q = '{8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    send_frame();
    check_tx("rd2_tx", 120 * CLK_DIV);
    check_bus("rd2", 200);
    repeat (CLK_DIV) @(negedge clk);

    // reset while a bus cycle is open
    slave_wait = 100000;
    frame = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
    send_frame();
    begin
      int k;
      k = 0;
      while (!wb_cyc && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    check("rstcyc_pre", wb_cyc, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstcyc_wb_cyc", wb_cyc, 1'b0);
    check("rstcyc_wb_stb", wb_stb, 1'b0);
    check("rstcyc_uart_tx", uart_tx, 1'b1);
    check("rstcyc_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    slave_wait = 0;
    repeat (5) @(negedge clk);
    got_q.delete();

    // reset while a TX byte is on the line
    slave_rdata = 32'h00000000;
    frame = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
    send_frame();
    begin
      int k;
      k = 0;
      while (uart_tx !== 1'b0 && k < 500) begin
        @(negedge clk);
        k++;
      end
    end
    repeat (3 * CLK_DIV) @(negedge clk);
    check("rsttx_pre", uart_tx, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rsttx_uart_tx", uart_tx, 1'b1);
    check("rsttx_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #(12 * BIT_T);
    got_q.delete();
    txb_q.delete();
    txt_q.delete();

    check("tx_stop_bits", tx_stop_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
